// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive sequencer: state encoding,
// oversampling ratios and the tick-count compare helper.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_t;

    localparam int OVS_HIGH = 16;
    localparam int OVS_LOW  = 8;

    // Tick count at which a decision is taken: mid start bit (half) or end of a full bit.
    function automatic logic [3:0] ovs_last(input logic ovs16, input logic half);
        int n;
        n = ovs16 ? OVS_HIGH : OVS_LOW;
        return half ? 4'(n / 2 - 1) : 4'(n - 1);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Host-side result bundle of the UART receiver: received word, completion
// strobe, activity indication and frame/parity error flags.
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] DataOut;
    logic                  Done;
    logic                  Busy;
    logic                  FrameError;
    logic                  ParityError;

    modport master (output DataOut, Done, Busy, FrameError, ParityError);
    modport slave  (input  DataOut, Done, Busy, FrameError, ParityError);
endinterface

// File: rtl/uart_rx_ctrl_sync.sv
// Metastability synchronizer for the asynchronous RX line; every stage resets
// to the idle-high line level so reset never looks like a start bit.
module rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic ResetN,
    input  logic D,
    output logic Q
);
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) r_sync <= '1;
        else         r_sync <= {r_sync[SYNC_STAGES-2:0], D};
    end

    assign Q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, mid-bit sampling, word assembly and
// frame checking. Optional parity bit and ParityType port with UART_RX_PARITY_EN.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic ResetN,
    input  logic SampleTick,
    input  logic OverSel,
    input  logic SerialIn,
`ifdef UART_RX_PARITY_EN
    input  logic ParityType,
`endif
    uart_rx_ctrl_if.master rx_if
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    rx_state_t             r_state, w_next;
    logic                  w_rxs;
    logic [3:0]            r_tick;
    logic [BW-1:0]         r_bit;
    logic                  r_ovs16;
    logic                  r_armed;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_stop;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_frame_err;
    logic                  w_mid, w_end;

    rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .Clock  (Clock),
        .ResetN (ResetN),
        .D      (SerialIn),
        .Q      (w_rxs)
    );

    assign w_mid = SampleTick && (r_tick == ovs_last(r_ovs16, 1'b1));
    assign w_end = SampleTick && (r_tick == ovs_last(r_ovs16, 1'b0));

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (!w_rxs && r_armed) w_next = START;
            START:  if (w_mid) w_next = w_rxs ? IDLE : DATA;
            DATA: begin
                if (w_end && r_bit == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                    w_next = PARITY;
`else
                    w_next = STOP;
`endif
                end
            end
            PARITY: if (w_end) w_next = STOP;
            STOP:   if (w_end) w_next = DONE;
            DONE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // A tick coinciding with a state change is swallowed; each state counts from 0.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_tick      <= '0;
            r_bit       <= '0;
            r_ovs16     <= 1'b1;
            r_armed     <= 1'b1;
            r_done      <= 1'b0;
            r_data_out  <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (r_state != w_next)
                r_tick <= '0;
            else if (SampleTick)
                r_tick <= (r_tick == ovs_last(r_ovs16, 1'b0)) ? 4'd0 : r_tick + 4'd1;

            if (r_state == IDLE) r_ovs16 <= OverSel;

            if (r_state == START)             r_bit <= '0;
            else if (r_state == DATA && w_end) r_bit <= r_bit + BW'(1);

            // A broken stop bit disarms start detection until the line is seen high again.
            if (r_state == DONE) r_armed <= r_stop;
            else if (w_rxs)      r_armed <= 1'b1;

            r_done <= (r_state == DONE);
            if (r_state == DONE) begin
                r_data_out  <= r_shift;
                r_frame_err <= !r_stop;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (r_state == DATA && w_end) r_shift <= {w_rxs, r_shift[DATA_WIDTH-1:1]};
        if (r_state == STOP && w_end) r_stop  <= w_rxs;
    end

`ifdef UART_RX_PARITY_EN
    logic r_perr;
    logic r_parity_err;

    always_ff @(posedge Clock) begin
        if (r_state == PARITY && w_end) r_perr <= ((^r_shift) ^ w_rxs) != ParityType;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN)              r_parity_err <= 1'b0;
        else if (r_state == DONE) r_parity_err <= r_perr;
    end

    assign rx_if.ParityError = r_parity_err;
`else
    assign rx_if.ParityError = 1'b0;
`endif

    assign rx_if.DataOut    = r_data_out;
    assign rx_if.Done       = r_done;
    assign rx_if.Busy       = (r_state != IDLE);
    assign rx_if.FrameError = r_frame_err;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus random frames,
// checked against a frame-level model of the received word and error flags.
module tb_uart_rx_ctrl;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int TP = 4;

    logic Clock = 1'b0;
    logic ResetN;
    logic SampleTick;
    logic OverSel;
    logic SerialIn;
    logic ParityType;

    uart_rx_ctrl_if #(.DATA_WIDTH(8)) rx_if ();

    uart_rx_ctrl #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .Clock      (Clock),
        .ResetN     (ResetN),
        .SampleTick (SampleTick),
        .OverSel    (OverSel),
        .SerialIn   (SerialIn),
`ifdef UART_RX_PARITY_EN
        .ParityType (ParityType),
`endif
        .rx_if      (rx_if.master)
    );

    always #5 Clock = ~Clock;

    initial begin
        int tcnt;
        tcnt = 0;
        SampleTick = 1'b0;
        forever begin
            @(posedge Clock);
            #1;
            tcnt = (tcnt + 1) % TP;
            SampleTick = (tcnt == 0);
        end
    end

    int   cyc = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;
    int   cap_cyc = 0;
    logic [7:0] cap_data = '0;
    logic cap_fe = 1'b0, cap_pe = 1'b0, cap_busy = 1'b0;
    logic prev_done = 1'b0, done_long = 1'b0;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (rx_if.Done) begin
            done_cnt <= done_cnt + 1;
            cap_data <= rx_if.DataOut;
            cap_fe   <= rx_if.FrameError;
            cap_pe   <= rx_if.ParityError;
            cap_busy <= rx_if.Busy;
            cap_cyc  <= cyc;
        end
        if (rx_if.Done && prev_done) done_long <= 1'b1;
        prev_done <= rx_if.Done;
        if (rx_if.Busy) busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timeout");
    end

    int   n_checks = 0;
    int   n_fail = 0;
    int   start_cyc = 0;
    bit   lat_chk = 1'b0;
    logic [7:0] exp_last = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_perr(input logic [7:0] d, input bit par, input bit ptype);
        if (!PAR_EN) return 1'b0;
        return ((($countones(d) + int'(par)) % 2) != int'(ptype));
    endfunction

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            while (!SampleTick) @(posedge Clock);
        end
    endtask

    task automatic set_line(input bit v);
        #2 SerialIn = v;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit ovs16, input bit stop,
                              input bit par, input bit hold_low);
        int n;
        n = ovs16 ? 16 : 8;
        OverSel = ovs16;
        wait_ticks(1);
        set_line(1'b0);
        start_cyc = cyc;
        if (lat_chk) begin
            @(posedge Clock); @(posedge Clock); #1;
            check("start_latency_before", rx_if.Busy, 0);
            @(posedge Clock); #1;
            check("start_latency_at", rx_if.Busy, 1);
        end
        wait_ticks(n);
        OverSel = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) begin
            set_line(d[i]);
            wait_ticks(n);
        end
        if (PAR_EN) begin
            set_line(par);
            wait_ticks(n);
        end
        set_line(stop);
        wait_ticks(n);
        if (!hold_low) begin
            set_line(1'b1);
            wait_ticks(n);
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input bit ovs16,
                             input bit stop, input bit par, input bit hold_low);
        int d0;
        d0 = done_cnt;
        send_frame(d, ovs16, stop, par, hold_low);
        #1;
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_data"}, cap_data, d);
        check({tag, "_frame_err"}, cap_fe, !stop);
        check({tag, "_parity_err"}, cap_pe, model_perr(d, par, ParityType));
        check({tag, "_busy_at_done"}, cap_busy, 0);
        check({tag, "_busy_after"}, rx_if.Busy, 0);
        exp_last = d;
    endtask

    initial begin
        int b0, d0, delta;
        logic [7:0] rd;
        ResetN = 1'b0;
        OverSel = 1'b1;
        SerialIn = 1'b1;
        ParityType = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check("reset_busy", rx_if.Busy, 0);
        check("reset_done", rx_if.Done, 0);
        check("reset_data", rx_if.DataOut, 0);
        check("reset_fe", rx_if.FrameError, 0);
        check("reset_pe", rx_if.ParityError, 0);
        #3 ResetN = 1'b1;
        wait_ticks(4);

        // 16x 0xA5 with start-detection latency
        lat_chk = 1'b1;
        run_frame("a5_16x", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        lat_chk = 1'b0;

        // 8x 0x3C with end-to-end timing bound
        run_frame("3c_8x", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        delta = cap_cyc - start_cyc;
        check("3c_8x_done_timing", (delta >= 72 * TP && delta <= (80 + 8 * PAR_EN) * TP + 3), 1);

        // Short low glitch: false start
        OverSel = 1'b1;
        wait_ticks(1);
        d0 = done_cnt;
        b0 = busy_cnt;
        set_line(1'b0);
        wait_ticks(3);
        set_line(1'b1);
        wait_ticks(32);
        #1;
        check("glitch_entered_start", busy_cnt > b0, 1);
        check("glitch_no_done", done_cnt, d0);
        check("glitch_data_hold", rx_if.DataOut, exp_last);
        check("glitch_busy", rx_if.Busy, 0);

        // Broken stop bit, line then held low
        run_frame("55_fe", 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
        d0 = done_cnt;
        b0 = busy_cnt;
        wait_ticks(48);
        #1;
        check("break_no_start", busy_cnt, b0);
        check("break_no_done", done_cnt, d0);
        check("break_hold_fe", rx_if.FrameError, 1);
        set_line(1'b1);
        wait_ticks(16);
        run_frame("after_break", 8'h96, 1'b0, 1'b1, 1'b1, 1'b0);

        // Odd parity, byte 0x01
        ParityType = 1'b1;
        run_frame("par_bit1", 8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
        check("par_bit1_flag", cap_pe, PAR_EN ? 1 : 0);
        run_frame("par_bit0", 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        check("par_bit0_flag", cap_pe, 0);

        // Reset in the 4th data bit
        OverSel = 1'b1;
        d0 = done_cnt;
        wait_ticks(1);
        set_line(1'b0);
        wait_ticks(16);
        rd = 8'h3B;
        for (int i = 0; i < 3; i++) begin
            set_line(rd[i]);
            wait_ticks(16);
        end
        set_line(rd[3]);
        wait_ticks(8);
        #3 ResetN = 1'b0;
        #1;
        check("abort_busy", rx_if.Busy, 0);
        check("abort_done", rx_if.Done, 0);
        check("abort_data", rx_if.DataOut, 0);
        check("abort_fe", rx_if.FrameError, 0);
        check("abort_pe", rx_if.ParityError, 0);
        SerialIn = 1'b1;
        repeat (3) @(posedge Clock);
        #3 ResetN = 1'b1;
        wait_ticks(32);
        #1;
        check("abort_no_done", done_cnt, d0);
        run_frame("f0_after_reset", 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Random frames
        for (int k = 0; k < 10; k++) begin
            logic [7:0] rdat;
            bit rovs, rstop, rpar;
            rdat  = 8'($urandom);
            rovs  = 1'($urandom_range(0, 1));
            rstop = ($urandom_range(0, 3) != 0);
            rpar  = 1'($urandom_range(0, 1));
            ParityType = 1'($urandom_range(0, 1));
            run_frame($sformatf("rand%0d", k), rdat, rovs, rstop, rpar, 1'b0);
        end

        check("done_single_cycle", done_long, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-path sequencer for the UART receiver. It consumes the oversampling tick from the `Sampling` baud generator and detects the start bit on the serial line. It then samples each bit at mid-bit, assembles the data word and checks the frame. The result goes to the host with a one-cycle `Done` strobe and error flags.

## Interface
- `DATA_WIDTH`, 8, data bits per frame (5..9).
- `SYNC_STAGES`, 2, flops in the `SerialIn` synchronizer (≥2).
- `Clock  in  1`  system clock, 50 MHz.
- `ResetN  in  1`  reset, asynchronous, active-low.
- `SampleTick  in  1`  one-`Clock` pulse from `Sampling` (its `BaudOut`), at 16× or 8× the baud rate.
- `OverSel  in  1`  oversampling ratio: 1 = 16×, 0 = 8×. Must match the setting on `Sampling`.
- `SerialIn  in  1`  asynchronous RX line, idle high.
- `ParityType  in  1`  1 = odd, 0 = even. Port exists only with `UART_RX_PARITY_EN`.
- `DataOut  out  DATA_WIDTH`  last received word, LSB first on the line.
- `Done  out  1`  one-cycle pulse when a frame completes.
- `Busy  out  1`  high while a frame is in progress (any state other than IDLE).
- `FrameError  out  1`  stop bit sampled 0 in the last frame.
- `ParityError  out  1`  parity mismatch in the last frame. Constant 0 without the macro.

## Operation
- `SerialIn` passes through `SYNC_STAGES` flops, each reset to 1, to give `RxS`. Every decision in this block uses `RxS`.
- On entry to START, latch the oversampling factor N (16 or 8) from `OverSel`. Changes to `OverSel` mid-frame are ignored.
- A 4-bit tick counter `TickCnt` advances only on `SampleTick`. It clears to 0 on every state transition.
- A bit counter `BitCnt` is ceil(log2(`DATA_WIDTH`)) bits wide.
- States and transitions:
  - IDLE: when `RxS`==0, go to START.
  - START: on the tick where `TickCnt`==N/2−1, sample `RxS`.
    - 0: go to DATA with `BitCnt`=0.
    - 1: false start, return to IDLE with no `Done` and no flag change.
  - DATA: on the tick where `TickCnt`==N−1, shift `RxS` into the MSB of the shift register (right shift) and increment `BitCnt`.
    - After bit `DATA_WIDTH`−1, go to PARITY if the macro is defined, else to STOP.
  - PARITY: on the tick where `TickCnt`==N−1, sample the parity bit.
    - Error = (XOR of the data bits XOR the parity bit) != `ParityType`.
  - STOP: on the tick where `TickCnt`==N−1, sample the stop bit and go to DONE.
  - DONE: one `Clock` only. Assert `Done`; load `DataOut`, `FrameError` (=!stop) and `ParityError`. Go to IDLE.
- After a frame error, do not start a new frame until `RxS` is 1 (break protection).
  - IDLE re-arms only after `RxS` has been sampled 1 at least once since DONE.
- `DataOut`, `FrameError` and `ParityError` hold their values until the next DONE.

## Timing
- Reset values:
  - state IDLE, synchronizer stages 1.
  - `DataOut`=0, `Done`=0, `Busy`=0, `FrameError`=0, `ParityError`=0.
- Reset is asynchronous at any point, including mid-frame. The block returns to IDLE at once and no `Done` is issued for the aborted frame.
- Start detection latency is `SYNC_STAGES`+1 `Clock` cycles from the falling edge of `SerialIn` to `Busy`=1.
- `Done` rises on the `Clock` edge after the `SampleTick` edge that samples the stop bit. It is high for exactly one cycle.
- `DataOut` and the error flags become valid on the same edge as `Done`.
- `Busy` falls on the same edge as `Done`.
- If `SampleTick` and a state transition fall in the same cycle, the tick is consumed by the transition; the new state counts from 0.
- No ticks arrive during the one-cycle DONE state, because the tick period is at least 2 `Clock` cycles.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The frame is start + `DATA_WIDTH` + parity + stop.
  - The `ParityType` port and the PARITY state exist.
- `UART_RX_PARITY_EN` undefined:
  - The frame is start + `DATA_WIDTH` + stop.
  - No `ParityType` port and no PARITY state.
  - `ParityError` is tied to 0.

## Structure
- Package `uart_rx_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, DONE);
  - the constants `OVS_HIGH`=16 and `OVS_LOW`=8.
- Sub-module `rx_sync`: a parameterised `SYNC_STAGES` flop chain that resets to 1.
- All other logic lives in `uart_rx_ctrl`.

## Test plan
- 16×, byte 0xA5 sent with a correct stop bit → `Done` pulses once, `DataOut`=0xA5, `FrameError`=0, `ParityError`=0, `Busy` low afterwards.
- 8×, byte 0x3C → `DataOut`=0x3C, with `Done` 10 bit-times (80 ticks) plus no more than 3 cycles after the start edge (no parity).
- Low glitch 3 ticks long at 16× → back to IDLE, no `Done`, `DataOut` unchanged.
- Byte 0x55 with stop bit 0 → `Done` pulses, `DataOut`=0x55, `FrameError`=1. With the line held low, no second frame starts until the line goes high.
- Parity macro on, `ParityType`=1 (odd), byte 0x01 with parity bit 1 → `ParityError`=1. The same byte with parity bit 0 → `ParityError`=0.
- `ResetN` pulsed low during the 4th data bit → `Busy`=0 immediately and all outputs are 0. The next clean 0xF0 frame is received correctly.
